// File: rtl/sar_avg_pkg.sv
// sar_avg_pkg: shared FSM type, default widths and rounding helper for the SAR averager
package sar_avg_pkg;
    typedef enum logic [1:0] {IDLE, REQ, REL, EMIT} state_e;
    localparam int NBITS_DEF   = 5;
    localparam int LOG2N_DEF   = 2;
    localparam int TIMEOUT_DEF = 64;
    localparam int ACC_W       = NBITS_DEF + LOG2N_DEF;
    localparam int TMO_W       = $clog2(TIMEOUT_DEF + 1);
    function automatic int round_const(input int log2n);
        return log2n > 0 ? 1 << (log2n - 1) : 0;
    endfunction
endpackage

// File: rtl/sar_avg_seq_if.sv
// sar_avg_seq_if: control, ADC and result-port signals of the averaging sequencer
interface sar_avg_seq_if #(parameter int NBITS = 5);
    logic             START;
    logic             CONT;
    logic             GO;
    logic             ADC_VALID;
    logic [NBITS-1:0] ADC_RESULT;
    logic [NBITS-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             BUSY;
    logic             OVERRUN;
    logic             TIMEOUT_ERR;
    modport master (
        input  START, CONT, ADC_VALID, ADC_RESULT, OUT_READY,
        output GO, OUT_DATA, OUT_VALID, BUSY, OVERRUN, TIMEOUT_ERR
    );
    modport slave (
        output START, CONT, ADC_VALID, ADC_RESULT, OUT_READY,
        input  GO, OUT_DATA, OUT_VALID, BUSY, OVERRUN, TIMEOUT_ERR
    );
endinterface

// File: rtl/sar_avg_acc.sv
// sar_avg_acc: code accumulator, sample counter and round-half-up mean
module sar_avg_acc
    import sar_avg_pkg::*;
#(
    parameter int NBITS = 5,
    parameter int LOG2N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [NBITS-1:0] din,
    output logic             done,
    output logic [NBITS-1:0] mean
);
    localparam int AW = NBITS + LOG2N;
    localparam int CW = LOG2N + 1;
    localparam logic [AW-1:0] RND = AW'(round_const(LOG2N));
    localparam logic [CW-1:0] N = CW'(1) << LOG2N;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;
    // clear wins over add; the sum cannot overflow AW bits
    always_comb begin
        acc_d = clr ? '0 : add ? acc_q + AW'(din) : acc_q;
        cnt_d = clr ? '0 : add ? cnt_q + CW'(1) : cnt_q;
        sum   = acc_q + RND;
    end
    // accumulator and sample-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
    assign done = cnt_q == N;
    assign mean = NBITS'(sum >> LOG2N);
endmodule

// File: rtl/sar_avg_seq.sv
// sar_avg_seq: ADC conversion sequencer averaging 2^LOG2N codes onto a valid/ready port
module sar_avg_seq
    import sar_avg_pkg::*;
#(
    parameter int NBITS   = NBITS_DEF,
    parameter int LOG2N   = LOG2N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           CLK,
    input logic           RST,
    sar_avg_seq_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             vld_q, vld_d;
    logic             go_q, go_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [NBITS-1:0] out_data_q, out_data_d;
    logic [NBITS-1:0] mean;
    logic             clr, add, ld, done, rise, tmo_hit;

    sar_avg_acc #(.NBITS(NBITS), .LOG2N(LOG2N)) u_acc (
        .clk (CLK),
        .rst (RST),
        .clr (clr),
        .add (add),
        .din (bus.ADC_RESULT),
        .done(done),
        .mean(mean)
    );

    // sequencer: VALID edge has priority over timeout; timeout drops the partial sum
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        add     = 1'b0;
        ld      = 1'b0;
        err_d   = err_q;
        vld_d   = bus.ADC_VALID;
        rise    = bus.ADC_VALID & ~vld_q;
        tmo_hit = tmo_q == TW'(TIMEOUT - 1);
        case (state_q)
            IDLE: if (bus.START | bus.CONT) begin
                clr     = 1'b1;
                err_d   = 1'b0;
                state_d = REQ;
            end
            REQ: if (rise) begin
                add     = 1'b1;
                state_d = REL;
            end else if (tmo_hit) begin
                clr     = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            REL: if (!bus.ADC_VALID) begin
                state_d = done ? EMIT : REQ;
            end else if (tmo_hit) begin
                clr     = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            EMIT: begin
                ld      = 1'b1;
                clr     = bus.CONT;
                state_d = bus.CONT ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        tmo_d  = (state_d != state_q || state_q == IDLE) ? '0 : tmo_q + TW'(1);
        go_d   = state_d == REQ;
        busy_d = state_d != IDLE;
    end

    // result register: an EMIT overwrites; overrun only when the held value was not taken
    always_comb begin
        out_valid_d = ld | (out_valid_q & ~bus.OUT_READY);
        out_data_d  = ld ? mean : out_data_q;
        ovr_d       = ovr_q | (ld & out_valid_q & ~bus.OUT_READY);
    end

    // all state and outputs are registered and clear on reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            vld_q       <= 1'b0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            vld_q       <= vld_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.GO          = go_q;
    assign bus.BUSY        = busy_q;
    assign bus.OVERRUN     = ovr_q;
    assign bus.TIMEOUT_ERR = err_q;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_DATA    = out_data_q;
endmodule

// File: doc/sar_avg_seq.md
# sar_avg_seq

Conversion sequencer and result averager placed directly downstream of the SAR ADC macro. It drives the ADC `GO` request and captures each finished code on the ADC `VALID` edge. It accumulates 2^LOG2N codes and presents their rounded mean on a valid/ready output port to the digital core. It also detects a stalled converter and reports when an unconsumed output is overwritten.

## Interface
Parameters:
- `NBITS`, 5: ADC code width; must match the converter.
- `LOG2N`, 2: log2 of the number of codes averaged; legal range 0..4.
- `TIMEOUT`, 64: maximum cycles in REQ without an ADC result; legal range 2..1023.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle request for one averaged result.
- `CONT`  in  1  level; while 1, a new average starts automatically after each emit.
- `GO`  out  1  to ADC `GO`.
- `ADC_VALID`  in  1  from ADC `VALID`.
- `ADC_RESULT`  in  NBITS  from ADC `RESULT`.
- `OUT_DATA`  out  NBITS  averaged code.
- `OUT_VALID`  out  1  `OUT_DATA` holds an unconsumed result.
- `OUT_READY`  in  1  consumer accepts the result.
- `BUSY`  out  1  FSM is not in IDLE.
- `OVERRUN`  out  1  sticky; an unconsumed result was overwritten.
- `TIMEOUT_ERR`  out  1  sticky; the ADC failed to answer.

## Operation
FSM states: IDLE, REQ, REL, EMIT.

- **IDLE:** on `START`=1 or `CONT`=1:
  - clear the accumulator and sample counter, clear `TIMEOUT_ERR`;
  - go to REQ.
- **REQ:** `GO`=1; the timeout counter increments every cycle.
  - **Rising edge of `ADC_VALID`:** on a cycle where `ADC_VALID`=1 and the previous registered value was 0:
    - add `ADC_RESULT` (zero-extended) to the accumulator;
    - increment the sample counter;
    - go to REL.
  - **Timeout:** when the timeout counter reaches `TIMEOUT` with no edge:
    - set `TIMEOUT_ERR`;
    - discard the partial accumulation;
    - go to IDLE;
    - ignore `CONT` for that cycle.
- **REL:** `GO`=0; wait for `ADC_VALID`=0.
  - Then go to REQ if the sample count < 2^LOG2N, else go to EMIT.
  - The timeout counter also runs in REL and is reset on each state entry. A REL timeout takes the same action as a REQ timeout.
- **EMIT:** a one-cycle state.
  - Load `OUT_DATA` = (acc + (LOG2N>0 ? 2^(LOG2N-1) : 0)) >> LOG2N. This is round-half-up.
  - Set `OUT_VALID`=1.
  - Next state is REQ (with the accumulator cleared) if `CONT`=1, else IDLE.

Arithmetic and width rules:
- The accumulator is NBITS+LOG2N bits wide.
- The maximum sum plus the rounding term is less than 2^(NBITS+LOG2N), so no saturation is needed.
- The result never exceeds 2^NBITS−1.

Output handshake:
- A transfer occurs on any cycle with `OUT_VALID`=1 and `OUT_READY`=1; `OUT_VALID` clears on the next cycle.
- `OUT_DATA` is stable while `OUT_VALID`=1, except when overwritten by an EMIT.

Boundary conditions:
- **EMIT while `OUT_VALID`=1 and `OUT_READY`=0:** the new value overwrites the held one, `OUT_VALID` stays 1, and `OVERRUN` is set.
- **EMIT in the same cycle as a transfer:** the old value is consumed, the new value is loaded, `OVERRUN` is unchanged.
- **`START` while `BUSY`:** ignored.
- **`CONT` falling mid-burst:** the current average completes, then the FSM goes to IDLE.
- **`ADC_VALID` already 1 on entry to REQ:** not counted until it falls and rises again.
- **`RST` mid-operation:** the FSM returns to IDLE. `GO`, `OUT_VALID`, `OVERRUN`, `TIMEOUT_ERR`, `BUSY`, `OUT_DATA`, the accumulator and all counters clear to 0 on the next edge. The converter sees `GO` drop.
- **Clearing `OVERRUN`:** only `RST` clears it.

## Timing
- All outputs are registered; every output is 0 after reset.
- `GO` rises 1 cycle after `START` is sampled.
- `ADC_VALID` is registered once for edge detection. The accumulation happens on the same edge that leaves REQ, so `GO` falls 1 cycle after `ADC_VALID` is sampled high.
- With an ADC that answers in C cycles and releases `VALID` 1 cycle after `GO` falls:
  - per-sample period is C+3 cycles;
  - `OUT_VALID` rises 1 cycle after the final REL exits.
- `BUSY` is 1 from the cycle after `START` through the EMIT cycle.
- `TIMEOUT_ERR` rises exactly `TIMEOUT` cycles after entry to REQ.

## Structure
- Package `sar_avg_pkg`:
  - FSM state enum;
  - localparams `ACC_W` = NBITS+LOG2N and `TMO_W` = $clog2(TIMEOUT+1);
  - function computing the rounding constant.
- Sub-module `sar_avg_acc` holds the accumulator, sample counter and rounding/shift datapath. Its controls are clear and add, and it outputs a done flag and the rounded mean.
- The top holds the FSM, edge detector, timeout counter and output register.

## Test plan
- **Single average:** NBITS=5, LOG2N=2, ADC model returns 3,4,4,5 with C=8 → exactly 4 `GO` pulses, then `OUT_DATA`=4, `OUT_VALID`=1, `BUSY`=0.
- **Rounding and extremes:**
  - codes 31,31,31,31 → 31;
  - codes 0,0,0,2 → 1 (2/4=0.5 rounds up);
  - codes 0,0,0,1 → 0.
- **Continuous with backpressure:** `CONT`=1, `OUT_READY`=0 for two averages → second value overwrites the first and `OVERRUN`=1; then `OUT_READY`=1 → one transfer and `OUT_VALID` clears.
- **Timeout:** the ADC never asserts `VALID`, `TIMEOUT`=16 → `TIMEOUT_ERR`=1 exactly 16 cycles after `GO` rises, `GO`=0, FSM in IDLE; the next `START` clears `TIMEOUT_ERR`.
- **Reset mid-burst:** `RST` during the second sample → all outputs 0 on the next edge; the next `START` produces a full 4-sample average unaffected by pre-reset data.
- **Stuck VALID and ignored START:** `ADC_VALID` held 1 at entry to REQ → no accumulation until it toggles; `START` pulsed while `BUSY` → no extra `GO` pulses.
